// File: rtl/cam_frame_capture.sv
// +-----------------------------------------------------------------------------+
// | Module   : cam_frame_capture                                                |
// | Brief    : Single-frame camera capture into a FWFT pixel buffer.            |
// |            Optional geometry check: CAM_FRAME_CAPTURE_GEOMCHK_EN            |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module cam_frame_capture #(
  parameter int WIDTH      = 3,
  parameter int HEIGHT     = 2,
  parameter int DATA_W     = 10,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              CAM_FRAME_VALID,
  input  logic              CAM_LINE_VALID,
  input  logic [DATA_W-1:0] CAM_DATA,
  output logic [OUT_W-1:0]  PIX_DATA,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW,
  output logic              ERR
);

  localparam int c_col_w  = $clog2(WIDTH + 1);
  localparam int c_row_w  = $clog2(HEIGHT + 1);
  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_col_w-1:0]  c_width  = c_col_w'(WIDTH);
  localparam logic [c_row_w-1:0]  c_height = c_row_w'(HEIGHT);
  localparam logic [c_addr_w:0]   c_depth  = (c_addr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_FV_LOW  = 2'd1,
    WAIT_FV_HIGH = 2'd2,
    CAPTURE      = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [c_col_w-1:0]  r_col;
  logic [c_row_w-1:0]  r_row;
  logic [c_row_w-1:0]  w_row_inc;
  logic                r_lv_d;
  logic                r_done;
  logic                r_overflow;
  logic [OUT_W-1:0]    r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_count;

  logic w_start_ok;
  logic w_enter_cap;
  logic w_frame_end;
  logic w_pix_cycle;
  logic w_lv_fall;
  logic w_wr_req;
  logic w_full;
  logic w_rd;
  logic w_wr;
  logic w_unused_data;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    BUSY         = (r_state != IDLE);
    case (r_state)
      IDLE:         if (START)            w_state_next = WAIT_FV_LOW;
      WAIT_FV_LOW:  if (!CAM_FRAME_VALID) w_state_next = WAIT_FV_HIGH;
      WAIT_FV_HIGH: if (CAM_FRAME_VALID)  w_state_next = CAPTURE;
      CAPTURE:      if (!CAM_FRAME_VALID) w_state_next = IDLE;
      default:                            w_state_next = IDLE;
    endcase
  end

  assign w_start_ok  = (r_state == IDLE) && START;
  assign w_enter_cap = (r_state == WAIT_FV_HIGH) && CAM_FRAME_VALID;
  assign w_frame_end = (r_state == CAPTURE) && !CAM_FRAME_VALID;
  assign w_pix_cycle = (r_state == CAPTURE) && CAM_FRAME_VALID && CAM_LINE_VALID;
  // A line also ends when frame valid drops together with line valid.
  assign w_lv_fall   = (r_state == CAPTURE) && r_lv_d && !w_pix_cycle;
  assign w_row_inc   = (r_row == c_height) ? r_row : r_row + 1'b1;
  assign w_wr_req    = w_pix_cycle && (r_col < c_width) && (r_row < c_height);

  always_ff @(posedge CLK) begin
    if (RST || w_enter_cap) begin
      r_col  <= '0;
      r_row  <= '0;
      r_lv_d <= 1'b0;
    end else if (r_state == CAPTURE) begin
      r_lv_d <= w_pix_cycle;
      if (w_lv_fall) begin
        r_col <= '0;
        r_row <= w_row_inc;
      end else if (w_pix_cycle && (r_col != c_width)) begin
        r_col <= r_col + 1'b1;
      end
    end else begin
      r_lv_d <= 1'b0;
    end
  end

  // Output buffer: first-word-fall-through, read side sees the head entry directly.
  assign w_rd   = PIX_VALID && PIX_READY;
  assign w_full = (r_count == c_depth);
  assign w_wr   = w_wr_req && (!w_full || w_rd);

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= CAM_DATA[DATA_W-1 -: OUT_W];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_start_ok)                      r_overflow <= 1'b0;
      else if (w_wr_req && w_full && !w_rd) r_overflow <= 1'b1;
    end
  end

`ifdef CAM_FRAME_CAPTURE_GEOMCHK_EN
  logic               r_err;
  logic [c_row_w-1:0] w_row_final;
  logic               w_geom_bad;

  assign w_row_final = w_lv_fall ? w_row_inc : r_row;
  assign w_geom_bad  = (w_lv_fall && (r_row < c_height) && (r_col != c_width)) ||
                       (w_frame_end && (w_row_final != c_height));

  always_ff @(posedge CLK) begin
    if (RST)             r_err <= 1'b0;
    else if (w_start_ok) r_err <= 1'b0;
    else if (w_geom_bad) r_err <= 1'b1;
  end

  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

  // Low pixel bits are intentionally truncated.
  assign w_unused_data = ^CAM_DATA;

  assign PIX_DATA  = r_mem[r_rd_ptr];
  assign PIX_VALID = (r_count != '0);
  assign DONE      = r_done;
  assign OVERFLOW  = r_overflow;

endmodule

`default_nettype wire
